keycode_in_pio: RTL
===================

// Module: keycode_in_pio
// PURPOSE
//  Avalon-MM slave input port: inverse direction of the keycode output PIO. Captures 8-bit
//  keycodes from a hardware source (USB/PS2 decoder side) into a small FIFO that the Nios CPU
//  drains over the bus. Provides status, interrupt masking and a sticky overflow flag.
//  Sits between the keyboard front-end logic and the system interconnect.
// PARAMETERS
//  DEPTH  8  FIFO entries; power of two, 2..16
//  DEDUP  1  1: push only when key_in differs from last pushed value; 0: push every strobe
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous, active-low reset
//  address    in   2   register select
//  chipselect in   1   slave select
//  read_n     in   1   active-low read strobe
//  write_n    in   1   active-low write strobe
//  writedata  in   32  write data
//  readdata   out  32  read data, combinational from address/state (read latency 0)
//  key_in     in   8   keycode from hardware source
//  key_valid  in   1   single-cycle strobe, key_in valid this cycle
//  irq        out  1   interrupt request, level
// BEHAVIOUR
//  Register map (unused readdata bits = 0):
//   0 DATA   R : [7:0] FIFO head; 0 when empty. Read (cs & ~read_n) pops head if not empty.
//   1 STATUS R/W: [4:0] count, [8] empty, [9] full, [10] overflow (sticky).
//              Write with writedata[10]=1 clears overflow; other bits ignored.
//   2 IRQMASK R/W: [0] not-empty enable, [1] overflow enable. Write loads [1:0].
//   3 LAST   R : [7:0] last keycode accepted for push (updated even when dropped on full).
//  Reset: FIFO empty, count=0, overflow=0, mask=0, LAST=0, irq=0, readdata reflects these.
//  Push: on key_valid and (DEDUP=0 or key_in != LAST, or no push yet since reset):
//   - LAST <= key_in; if not full, write at tail, tail++ mod DEPTH; else drop, overflow<=1.
//   - DEDUP compare uses LAST; first key after reset always accepted, including 8'h00.
//  Pop: edge after cs & ~read_n & address==0 with count>0; head++ mod DEPTH.
//   Reads of other addresses, or when empty, have no side effect.
//  Pointers: log2(DEPTH)-bit head/tail, wrap naturally; count is log2(DEPTH)+1 bits.
//  Simultaneous push+pop: both occur, count unchanged; when full, push is NOT dropped
//   and overflow not set (pop frees slot same edge). When empty, pop ignored, push occurs.
//  Write and read in same cycle (both strobes low): write takes effect, read side effect also.
//  Overflow clear coincident with new overflow event: set wins.
//  irq = (mask[0] & ~empty) | (mask[1] & overflow); combinational from registered state,
//   i.e. asserts the cycle after the causing edge; no glitch paths from bus inputs.
//  Push/pop new value visible on readdata the cycle after the edge.
//  reset_n asserted mid-operation: all state cleared immediately; contents discarded.
// TESTING
//  1 Reset: read all 4 addrs -> DATA=0, STATUS=0x100, IRQMASK=0, LAST=0, irq=0.
//  2 Push 0x1A,0x04,0x16 (DEDUP=1) -> STATUS count=3; DATA reads return 0x1A,0x04,0x16 then 0.
//  3 DEDUP=1, key_valid 0x07 on 5 consecutive cycles -> count=1; DEDUP=0 same -> count=5.
//  4 Push 9 distinct keys into DEPTH=8 -> full=1, overflow=1, LAST=9th key, DATA=1st key;
//    write STATUS 0x400 -> overflow=0; irq follows mask[1] accordingly.
//  5 Full FIFO, push 0x2C while reading DATA same cycle -> returns old head, count stays 8,
//    overflow stays 0; 8 further reads end with 0x2C.
//  6 IRQMASK=1, push one key -> irq=1 next cycle; read DATA -> irq=0 cycle after pop;
//    assert reset_n low with 4 entries -> count=0, irq=0 immediately.

Source files
------------

// File: rtl/keycode_in_pio.sv
// Avalon-MM input PIO: queues keycodes from the keyboard front-end in a small FIFO
// that the CPU drains over the bus, with status, interrupt masking and sticky overflow.
module keycode_in_pio #(
    parameter int unsigned DEPTH = 8,
    parameter bit          DEDUP = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  key_in,
    input  logic        key_valid,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned KW = 8;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_LAST   = 2'd3;

    logic [KW-1:0] mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    mask_q, mask_d;
    logic [KW-1:0] last_q, last_d;
    logic          seen_q, seen_d;

    logic wr_c, empty_c, full_c, accept_c, pop_c, push_c, drop_c;

    // Bus strobes and FIFO push/pop qualification
    always_comb begin
        wr_c     = chipselect & ~write_n;
        empty_c  = (count_q == CW'(0));
        full_c   = (count_q == CW'(DEPTH));
        pop_c    = chipselect & ~read_n & (address == ADDR_DATA) & ~empty_c;
        accept_c = key_valid & (~DEDUP | ~seen_q | (key_in != last_q));
        // A pop on the same edge frees a slot, so a full FIFO still takes the push
        push_c   = accept_c & (~full_c | pop_c);
        drop_c   = accept_c & full_c & ~pop_c;
    end

    // Next-state logic
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        mask_d  = mask_q;
        last_d  = last_q;
        seen_d  = seen_q;

        if (accept_c) begin
            last_d = key_in;
            seen_d = 1'b1;
        end
        if (push_c) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop_c) begin
            head_d = head_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_c && (address == ADDR_STATUS) && writedata[10]) begin
            ovf_d = 1'b0;
        end
        // A new overflow outranks a clear on the same edge
        if (drop_c) begin
            ovf_d = 1'b1;
        end
        if (wr_c && (address == ADDR_MASK)) begin
            mask_d = writedata[1:0];
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            mask_q  <= '0;
            last_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            seen_q  <= seen_d;
        end
    end

    // FIFO storage; contents are meaningless once pointers reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[tail_q] <= key_in;
        end
    end

    // Zero-latency read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: begin
                if (!empty_c) begin
                    readdata[KW-1:0] = mem_q[head_q];
                end
            end
            ADDR_STATUS: begin
                readdata[4:0] = 5'(count_q);
                readdata[8]   = empty_c;
                readdata[9]   = full_c;
                readdata[10]  = ovf_q;
            end
            ADDR_MASK: readdata[1:0]    = mask_q;
            ADDR_LAST: readdata[KW-1:0] = last_q;
            default:   readdata = '0;
        endcase
    end

    assign irq = (mask_q[0] & ~empty_c) | (mask_q[1] & ovf_q);

endmodule
